fault_detector: RTL and testbench
=================================

# fault_detector

Upstream fault-sensing stage for the recovery path: inspects the decoded instruction and the main-control bundle every cycle. Produces the registered `illegal_opcode`, `invalid_control` and `stuck_at_fault` indications that drive the fault classifier / recovery FSM block. Also captures the PC of the first unrecovered fault for debug and checkpoint logic. Detection is masked while recovery is in progress.

## Interface
- `STUCK_LIMIT`, 16: consecutive stalled-PC cycles that constitute a stuck-at fault; legal range 2..255.
- `XLEN`, 32: PC/instruction width.

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  `instr` and control bundle are meaningful this cycle
- `instr`  in  XLEN  fetched instruction word
- `reg_write`  in  1  main-control register write enable
- `mem_write`  in  1  main-control store enable
- `mem_read`  in  1  main-control load enable
- `branch`  in  1  main-control branch
- `jump`  in  1  main-control jal/jalr
- `pc_write`  in  1  PC update enable this cycle
- `pc_current`  in  XLEN  current PC
- `fault_mask`  in  1  recovery in progress (freeze or recover); suppresses detection
- `fault_clear`  in  1  one-cycle pulse on recovery completion
- `illegal_opcode`  out  1  registered illegal-instruction flag
- `invalid_control`  out  1  registered inconsistent-control flag
- `stuck_at_fault`  out  1  registered stalled-PC flag
- `fault_valid`  out  1  sticky: a fault has been captured since the last clear
- `fault_pc`  out  XLEN  PC of the first captured fault

## Operation
- Legal opcodes (`instr[6:0]`): 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111.
- Illegal condition: `instr_valid` and either (`instr[1:0]` != 2'b11) or the opcode is not in the legal set.
- Invalid-control condition: `instr_valid` and any of:
  - `mem_write & mem_read`
  - `mem_write & reg_write`
  - `branch & jump`
- Stuck-at counter `stuck_cnt`:
  - Width `$clog2(STUCK_LIMIT+1)`.
  - Compares `pc_current` against `pc_prev`, a register loaded every cycle.
  - Increments when `instr_valid & pc_write & (pc_current == pc_prev)`.
  - Saturates at STUCK_LIMIT.
  - Clears to 0 on any other cycle, or when `fault_mask` is high.
  - Stuck condition: `stuck_cnt == STUCK_LIMIT`. A legitimate self-loop (`jal x0,0`) is intentionally reported as a fault; this is watchdog semantics.
- Flags:
  - Each output flag is the registered AND of its condition with `!fault_mask`.
  - Flags are levels: they stay high as long as the condition persists, with no internal pulse-stretch.
- Capture:
  - Trigger: any unmasked condition true while `fault_valid == 0`.
  - Effect: `fault_pc <= pc_current` and `fault_valid <= 1`.
  - Later faults do not overwrite `fault_pc`.
- Clear:
  - `fault_clear` sets `fault_valid <= 0`. `fault_pc` holds its value.
  - If `fault_clear` and a new unmasked condition occur in the same cycle, the capture wins: `fault_valid` stays 1 and `fault_pc` loads the new PC. No fault is lost.

## Timing
- Reset values: all flags 0, `fault_valid` 0, `fault_pc` 0, `stuck_cnt` 0, `pc_prev` 0.
- Latency: 1 cycle from input to flag. For example, an illegal instruction presented in cycle N raises `illegal_opcode` in N+1.
- Stuck latency: the first repeated-PC cycle is C1; `stuck_at_fault` goes high in cycle C(STUCK_LIMIT)+1.
- `fault_mask` takes effect on the next edge: flags fall one cycle after the mask rises, and the counter is zero one cycle after.
- `reset` mid-operation overrides everything, including capture, in that cycle.
- `instr_valid = 0` produces no illegal or invalid flags and clears `stuck_cnt`.

## Configuration
- Macro: `FAULT_DETECT_STUCK_EN`.
- Defined: stuck-at counter, `pc_prev` register and compare logic are present, as described above.
- Undefined: counter, `pc_prev` and compare logic are removed. `stuck_at_fault` is tied 0 and does not contribute to capture. All other behaviour is unchanged.

## Structure
- Shared package `fault_pkg`: the opcode localparams above, the fault-type encodings (none 2'b00, minor 2'b01, critical 2'b10), and the `STUCK_LIMIT` default.
- One sub-module, `opcode_legality_checker`: combinational; `instr` in, `illegal` out. It is reused by the decoder's assertion checks.
- The top level holds the counter, registers and capture logic.

## Test plan
- Reset, then `instr = 32'h0000_0013` (addi) with valid, consistent control -> all flags 0 every cycle, `fault_valid` 0.
- `instr = 32'h0000_007F` at PC 0x40 in cycle N -> `illegal_opcode` = 1 in N+1; `fault_valid` = 1; `fault_pc` = 0x40.
- `mem_write = mem_read = 1` at PC 0x80, then a second fault at 0xC0 -> `invalid_control` = 1 one cycle later; `fault_pc` stays 0x80.
- `pc_write = 1`, `pc_current` held at 0x100 for 20 cycles, STUCK_LIMIT = 16 -> `stuck_at_fault` rises on the 17th cycle after the first repeat. With the macro undefined, it stays 0.
- Illegal opcode present with `fault_mask = 1` -> no flag. Then `fault_clear` coinciding with a new illegal instruction at 0x200 -> `fault_valid` stays 1 and `fault_pc` = 0x200.
- Assert `reset` during a stuck count of 10 -> all outputs 0 next cycle; count restarts from 0.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared definitions for the fault-sensing path: legal opcodes, fault-type
// encodings and the default stuck-PC limit.
package fault_pkg;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MINOR    = 2'b01,
      FAULT_CRITICAL = 2'b10
   } fault_type_e;

   localparam int STUCK_LIMIT_DEFAULT = 16;

   function automatic logic opcode_is_legal(input logic [6:0] op);
      case (op)
         OP_R_TYPE, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
         OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/opcode_legality_checker.sv
// Combinational legality test of an instruction word; shared with the
// decoder's assertion checks.
module opcode_legality_checker
   import fault_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr,
   output logic            illegal
);

   // Only the opcode field matters; the upper bits are deliberately ignored.
   logic unused_upper;
   assign unused_upper = ^instr[XLEN-1:7];

   assign illegal = (instr[1:0] != 2'b11) || !opcode_is_legal(instr[6:0]);

endmodule

// File: rtl/fault_detector.sv
// Per-cycle fault sensing: illegal opcode, inconsistent control, stalled PC,
// plus first-fault PC capture. Stalled-PC watchdog built only with FAULT_DETECT_STUCK_EN.
module fault_detector
   import fault_pkg::*;
#(
   parameter int STUCK_LIMIT = STUCK_LIMIT_DEFAULT,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr,
   input  logic            reg_write,
   input  logic            mem_write,
   input  logic            mem_read,
   input  logic            branch,
   input  logic            jump,
   input  logic            pc_write,
   input  logic [XLEN-1:0] pc_current,
   input  logic            fault_mask,
   input  logic            fault_clear,
   output logic            illegal_opcode,
   output logic            invalid_control,
   output logic            stuck_at_fault,
   output logic            fault_valid,
   output logic [XLEN-1:0] fault_pc
);

   logic            illegal_raw;
   logic            illegal_hit;
   logic            invalid_hit;
   logic            stuck_hit;
   logic            any_hit;
   logic            illegal_opcode_reg;
   logic            invalid_control_reg;
   logic            stuck_at_fault_reg;
   logic            fault_valid_reg;
   logic [XLEN-1:0] fault_pc_reg;

   opcode_legality_checker #(.XLEN(XLEN)) u_opcode_check (
      .instr   (instr),
      .illegal (illegal_raw)
   );

   assign illegal_hit = instr_valid & illegal_raw & ~fault_mask;
   assign invalid_hit = instr_valid & ~fault_mask &
                        ((mem_write & mem_read) | (mem_write & reg_write) | (branch & jump));

`ifdef FAULT_DETECT_STUCK_EN
   localparam int CNT_W = $clog2(STUCK_LIMIT + 1);

   logic [CNT_W-1:0] stuck_cnt_reg;
   logic [CNT_W-1:0] stuck_cnt_next;
   logic [XLEN-1:0]  pc_prev_reg;

   always_comb begin
      stuck_cnt_next = '0;
      if (!fault_mask && instr_valid && pc_write && (pc_current == pc_prev_reg)) begin
         if (stuck_cnt_reg == CNT_W'(STUCK_LIMIT))
            stuck_cnt_next = stuck_cnt_reg;
         else
            stuck_cnt_next = stuck_cnt_reg + CNT_W'(1);
      end
   end

   // Flag tracks the counter value it registers alongside, so it is high in
   // the cycle right after the counter's STUCK_LIMIT-th repeat.
   assign stuck_hit = (stuck_cnt_next == CNT_W'(STUCK_LIMIT));

   always_ff @(posedge clk) begin
      if (reset) begin
         stuck_cnt_reg <= '0;
         pc_prev_reg   <= '0;
      end else begin
         stuck_cnt_reg <= stuck_cnt_next;
         pc_prev_reg   <= pc_current;
      end
   end
`else
   localparam int unused_stuck_limit = STUCK_LIMIT;
   logic unused_stuck_inputs;
   assign unused_stuck_inputs = pc_write;
   assign stuck_hit = 1'b0;
`endif

   assign any_hit = illegal_hit | invalid_hit | stuck_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_opcode_reg  <= 1'b0;
         invalid_control_reg <= 1'b0;
         stuck_at_fault_reg  <= 1'b0;
         fault_valid_reg     <= 1'b0;
         fault_pc_reg        <= '0;
      end else begin
         illegal_opcode_reg  <= illegal_hit;
         invalid_control_reg <= invalid_hit;
         stuck_at_fault_reg  <= stuck_hit;
         // A clear in the same cycle as a new fault re-arms and captures it.
         if (any_hit && (!fault_valid_reg || fault_clear)) begin
            fault_valid_reg <= 1'b1;
            fault_pc_reg    <= pc_current;
         end else if (fault_clear) begin
            fault_valid_reg <= 1'b0;
         end
      end
   end

   assign illegal_opcode  = illegal_opcode_reg;
   assign invalid_control = invalid_control_reg;
   assign stuck_at_fault  = stuck_at_fault_reg;
   assign fault_valid     = fault_valid_reg;
   assign fault_pc        = fault_pc_reg;

endmodule

// File: tb/tb_fault_detector.sv
// Self-checking bench for fault_detector: directed scenarios followed by
// randomized bursts, all compared against a cycle-level behavioural model.
module tb_fault_detector;

   localparam int LIMIT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instr;
   logic        reg_write, mem_write, mem_read, branch, jump, pc_write;
   logic [31:0] pc_current;
   logic        fault_mask, fault_clear;
   logic        illegal_opcode, invalid_control, stuck_at_fault, fault_valid;
   logic [31:0] fault_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   bit          m_ill, m_inv, m_stuck, m_valid;
   logic [31:0] m_pc, m_prev;
   int          m_run;

   logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111, 7'b1110011, 7'b0001111};

   always #5 clk = ~clk;

   fault_detector #(.STUCK_LIMIT(LIMIT), .XLEN(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .reg_write       (reg_write),
      .mem_write       (mem_write),
      .mem_read        (mem_read),
      .branch          (branch),
      .jump            (jump),
      .pc_write        (pc_write),
      .pc_current      (pc_current),
      .fault_mask      (fault_mask),
      .fault_clear     (fault_clear),
      .illegal_opcode  (illegal_opcode),
      .invalid_control (invalid_control),
      .stuck_at_fault  (stuck_at_fault),
      .fault_valid     (fault_valid),
      .fault_pc        (fault_pc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit is_illegal(input logic [31:0] w);
      bit found = 0;
      foreach (legal_ops[i]) if (w[6:0] == legal_ops[i]) found = 1;
      return (w[1:0] != 2'b11) || !found;
   endfunction

   // Advance one clock: update the model from the current inputs, then
   // compare every output against it just after the edge.
   task automatic step(input bit verbose);
      bit ci, cv, cs;
      if (reset) begin
         {m_ill, m_inv, m_stuck, m_valid} = '0;
         m_pc = '0; m_prev = '0; m_run = 0;
      end else begin
         ci = instr_valid && !fault_mask && is_illegal(instr);
         cv = instr_valid && !fault_mask &&
              ((mem_write && mem_read) || (mem_write && reg_write) || (branch && jump));
`ifdef FAULT_DETECT_STUCK_EN
         if (!fault_mask && instr_valid && pc_write && pc_current == m_prev) m_run++;
         else m_run = 0;
         cs = (m_run >= LIMIT);
`else
         cs = 0;
`endif
         m_prev = pc_current;
         if ((ci || cv || cs) && (!m_valid || fault_clear)) begin
            m_valid = 1;
            m_pc    = pc_current;
         end else if (fault_clear) begin
            m_valid = 0;
         end
         m_ill = ci; m_inv = cv; m_stuck = cs;
      end
      @(posedge clk);
      #1;
      check("illegal_opcode",  32'(illegal_opcode),  32'(m_ill));
      check("invalid_control", 32'(invalid_control), 32'(m_inv));
      check("stuck_at_fault",  32'(stuck_at_fault),  32'(m_stuck));
      check("fault_valid",     32'(fault_valid),     32'(m_valid));
      check("fault_pc",        fault_pc,             m_pc);
      if (verbose)
         $display("[TB] t=%0t pc=%08h instr=%08h -> ill=%0b inv=%0b stuck=%0b valid=%0b fpc=%08h",
                  $time, pc_current, instr, illegal_opcode, invalid_control,
                  stuck_at_fault, fault_valid, fault_pc);
   endtask

   task automatic set_clean(input logic [31:0] pc);
      reset = 0; instr_valid = 1; instr = 32'h0000_0013;
      reg_write = 1; mem_write = 0; mem_read = 0; branch = 0; jump = 0;
      pc_write = 1; pc_current = pc; fault_mask = 0; fault_clear = 0;
   endtask

   initial begin
      set_clean(32'h0);
      reset = 1; instr_valid = 0; pc_write = 0; reg_write = 0;
      step(1); step(1);
      check("reset_valid", 32'(fault_valid), 32'h0);
      check("reset_pc", fault_pc, 32'h0);

      // clean addi stream
      for (int i = 1; i <= 5; i++) begin
         set_clean(32'(i * 4));
         step(1);
         check("clean_flags", 32'({illegal_opcode, invalid_control, stuck_at_fault, fault_valid}), 32'h0);
      end

      // illegal opcode at 0x40
      set_clean(32'h40); instr = 32'h0000_007F;
      step(1);
      check("dir_illegal", 32'(illegal_opcode), 32'h1);
      check("dir_ill_valid", 32'(fault_valid), 32'h1);
      check("dir_ill_pc", fault_pc, 32'h40);

      // clear, then two control faults; first PC must stick
      set_clean(32'h44); fault_clear = 1; step(1);
      check("dir_clear", 32'(fault_valid), 32'h0);
      set_clean(32'h80); reg_write = 0; mem_write = 1; mem_read = 1; step(1);
      check("dir_invalid", 32'(invalid_control), 32'h1);
      set_clean(32'hC0); branch = 1; jump = 1; step(1);
      check("dir_invalid2", 32'(invalid_control), 32'h1);
      check("dir_first_pc", fault_pc, 32'h80);

      // stalled PC
      set_clean(32'h44); fault_clear = 1; step(1);
      for (int j = 0; j <= 20; j++) begin
         set_clean(32'h100);
         step(1);
`ifdef FAULT_DETECT_STUCK_EN
         check("dir_stuck_edge", 32'(stuck_at_fault), 32'(j >= LIMIT));
`else
         check("dir_stuck_off", 32'(stuck_at_fault), 32'h0);
`endif
      end
`ifdef FAULT_DETECT_STUCK_EN
      check("dir_stuck_pc", fault_pc, 32'h100);
`endif

      // masked illegal, then clear coinciding with a new illegal
      set_clean(32'h1F0); instr = 32'hFFFF_FFFF; fault_mask = 1; pc_write = 0; step(1);
      check("dir_masked", 32'(illegal_opcode), 32'h0);
      set_clean(32'h1F8); instr = 32'h0000_007F; step(1);
      set_clean(32'h200); instr = 32'h0000_007F; fault_clear = 1; pc_write = 0; step(1);
      check("dir_clr_cap_valid", 32'(fault_valid), 32'h1);
      check("dir_clr_cap_pc", fault_pc, 32'h200);

      // reset during a stuck count of 10
      set_clean(32'h2FC); step(1);
      for (int j = 0; j <= 10; j++) begin set_clean(32'h300); step(0); end
      set_clean(32'h300); reset = 1; step(1);
      check("dir_rst_out", 32'({illegal_opcode, invalid_control, stuck_at_fault, fault_valid}), 32'h0);
      check("dir_rst_pc", fault_pc, 32'h0);
      for (int j = 0; j < LIMIT + 3; j++) begin set_clean(32'h300); step(0); end

      // randomized bursts
      for (int b = 0; b < 24; b++) begin
         bit hold = ($urandom_range(0, 2) == 0);
         int len  = hold ? $urandom_range(14, 24) : 15;
         logic [31:0] pc = {$urandom_range(0, 255), 2'b00};
         for (int k = 0; k < len; k++) begin
            reset       = ($urandom_range(0, 99) == 0);
            instr_valid = ($urandom_range(0, 99) < (hold ? 97 : 85));
            instr       = $urandom();
            if ($urandom_range(0, 1) == 1)
               instr[6:0] = legal_ops[$urandom_range(0, 10)];
            reg_write   = $urandom_range(0, 1);
            mem_write   = ($urandom_range(0, 3) == 0);
            mem_read    = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 3) == 0);
            jump        = ($urandom_range(0, 3) == 0);
            pc_write    = ($urandom_range(0, 99) < (hold ? 97 : 80));
            fault_mask  = ($urandom_range(0, 99) < (hold ? 3 : 10));
            fault_clear = ($urandom_range(0, 9) == 0);
            if (!hold && $urandom_range(0, 2) != 0)
               pc = {$urandom_range(0, 255), 2'b00};
            pc_current = pc;
            step(0);
         end
         $display("[TB] burst %0d (%s, %0d cycles) valid=%0b fpc=%08h",
                  b, hold ? "hold" : "mixed", len, fault_valid, fault_pc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
